spi_word_peripheral: RTL and testbench
======================================

Name: spi_word_peripheral

Overview:
- Parametrised SPI peripheral that frames WORD_BYTES-byte words in both directions.
- Supports all four SPI modes (CPOL/CPHA) and a true transmit shift path loaded per word.
- Provides a valid/ack receive handshake with sticky overrun and frame-error flags.
- Sits between the external SPI pins and the command/register decoder; everything is synchronised to clk.

Parameters:
- WORD_BYTES, 8: bytes per word; legal 1..16. Word width W = 8*WORD_BYTES.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- SYNC_STAGES, 3: SCK/CS synchroniser depth; legal >= 3. COPI uses SYNC_STAGES-1.

Ports:
- clk  in  1  system clock; f_clk >= 4*f_SCK.
- reset  in  1  asynchronous, active-high reset.
- SCK  in  1  SPI clock (async).
- CS  in  1  chip select, active low (async).
- COPI  in  1  controller-out data (async).
- CIPO  out  1  peripheral-out data.
- tx_word  in  W  next word to transmit; sampled at word load.
- tx_load  out  1  one-cycle pulse when tx_word has been captured.
- rx_word  out  W  last complete received word.
- rx_valid  out  1  level; high while rx_word is unacknowledged.
- rx_ack  in  1  clears rx_valid.
- overrun  out  1  sticky; a word completed while rx_valid was high.
- frame_err  out  1  sticky; CS deasserted mid-word.
- err_clr  in  1  clears overrun and frame_err.

Behaviour:
- Reset values (async): rx_word=0, rx_valid=0, tx_load=0, overrun=0, frame_err=0, state=IDLE, counters=0, synchronisers at idle (SCK=CPOL, CS=1, COPI=0).
- Synchronisation: SCK/CS through SYNC_STAGES flops; edges are detected on the last two stages. Sample edge = rising when CPOL==CPHA, else falling; the other edge is the shift edge.
- Bit/byte order: bytes little-endian (first byte <-> bits [7:0]); bits MSB-first within each byte, both directions.
- FSM state IDLE: CIPO per the optional feature. On synchronised CS falling: load tx shift register from tx_word, pulse tx_load, clear bit/byte counters, go to XFER.
- FSM state XFER, CPHA=0: CIPO presents the current MSB immediately. Each shift edge advances to the next bit; the shift edge before the first sample edge is ignored.
- FSM state XFER, CPHA=1: CIPO is updated on each shift edge, including the first.
- Each sample edge shifts COPI into the rx shift register and increments bit_cnt (3-bit, wraps). byte_cnt increments when bit_cnt wraps.
- Word complete = sample edge of bit 7 of byte WORD_BYTES-1. On the following clk:
  - rx_word <= shift register.
  - rx_valid <= 1; if rx_valid was already 1 and rx_ack is not asserted that cycle, overrun <= 1 and rx_word is still overwritten.
  - tx shift register <= tx_word; tx_load pulses; byte_cnt <= 0.
- XFER exit: synchronised CS rising returns to IDLE. If bit_cnt!=0 or byte_cnt!=0, set frame_err and discard the partial word (no rx_valid). Counters clear.
- rx_ack while rx_valid=1: rx_valid <= 0 next cycle. rx_ack coincident with a completion: completion wins, rx_valid stays 1, no overrun.
- err_clr coincident with a new error event: the set wins.
- Latency: CS pin to tx_load is SYNC_STAGES+1 clk. Last sample edge at pin to rx_valid is SYNC_STAGES+2 clk.
- Reset mid-transfer aborts immediately. frame_err is not set, since reset clears it.

Optional Feature:
- Macro SPI_CIPO_TRISTATE_EN.
- Defined: CIPO = 1'bz whenever synchronised CS is inactive (shared bus).
- Undefined: CIPO is driven 0 when inactive (point-to-point, no tristate inference).

Decomposition:
- Package spi_pkg holds the state enum (IDLE, XFER) and the mode-decode constants: sample-edge select as a function of CPOL/CPHA.
- Sub-module spi_sync_edge: a SYNC_STAGES synchroniser plus rise/fall detector, instantiated for SCK and CS.
- COPI uses a plain two-flop path inline.

Test Plan:
- Mode 0, WORD_BYTES=2, tx_word=16'hA55A: send 16'h1234 as bytes 34,12 -> rx_word=16'h1234 and rx_valid=1. CIPO bytes seen are 5A then A5, MSB first. tx_load pulses twice (CS fall, word end).
- Modes 1, 2, 3 each send byte 8'hC3 with WORD_BYTES=1 -> rx_word=8'hC3 and CIPO matches tx_word=8'h3C bit-for-bit.
- Two consecutive words with no rx_ack -> overrun=1 and rx_word=second word. err_clr -> overrun=0.
- CS raised after 13 bits (WORD_BYTES=2) -> frame_err=1 and rx_valid stays 0. A following complete word is received correctly.
- rx_ack on the same cycle as a word completion -> rx_valid stays 1 and overrun stays 0.
- Reset asserted mid-byte -> all outputs reach their reset values asynchronously. The next transfer is correct from bit 0.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared types and mode-decode helpers for the SPI word peripheral.
//            Holds the transfer FSM state encoding and the function that picks
//            the sample edge from CPOL/CPHA.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Sample on the rising SCK edge when CPOL == CPHA, otherwise on the falling
  // edge. The opposite edge is the shift edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Multi-flop synchroniser for an asynchronous pin followed by a
//            registered rise/fall detector on the last two stages.
// Ports    : clk     - system clock
//            reset   - asynchronous active-high reset
//            d_i     - asynchronous input pin
//            rise_o  - one-cycle pulse on a synchronised rising edge
//            fall_o  - one-cycle pulse on a synchronised falling edge
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              rise_q;
  logic              fall_q;

  // Stage [0] takes the pin; [STAGES-1] is the oldest. The edge pulses are
  // registered, so a pin edge shows up as a pulse STAGES clocks later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      rise_q <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
      fall_q <= ~sync_q[STAGES-2] & sync_q[STAGES-1];
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule
`default_nettype wire

// File: rtl/spi_word_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : spi_word_peripheral
// Purpose  : SPI peripheral framing WORD_BYTES-byte words in both directions,
//            any CPOL/CPHA mode, with a valid/ack receive handshake and sticky
//            overrun / frame-error flags. All logic runs on clk.
//            Optional macro SPI_CIPO_TRISTATE_EN: when defined CIPO floats
//            (1'bz) while deselected; otherwise it is driven low.
// Ports    : clk, reset       - system clock, async active-high reset
//            SCK, CS, COPI    - asynchronous SPI pins (CS active low)
//            CIPO             - peripheral-out data
//            tx_word/tx_load  - next transmit word / capture pulse
//            rx_word/rx_valid - last received word / unacknowledged flag
//            rx_ack           - clears rx_valid
//            overrun          - sticky: word completed while rx_valid high
//            frame_err        - sticky: CS released mid-word
//            err_clr          - clears overrun and frame_err
// Revision : 1.0 - initial release
// ============================================================================
module spi_word_peripheral
  import spi_pkg::*;
#(
  parameter int WORD_BYTES  = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    SCK,
  input  logic                    CS,
  input  logic                    COPI,
  output logic                    CIPO,
  input  logic [8*WORD_BYTES-1:0] tx_word,
  output logic                    tx_load,
  output logic [8*WORD_BYTES-1:0] rx_word,
  output logic                    rx_valid,
  input  logic                    rx_ack,
  output logic                    overrun,
  output logic                    frame_err,
  input  logic                    err_clr
);

  localparam int             W           = 8 * WORD_BYTES;
  localparam int             BCW         = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE   = BCW'(WORD_BYTES - 1);
  localparam int             COPI_STAGES = SYNC_STAGES - 1;
  localparam logic           SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic sample_pulse, shift_pulse, shift_ok;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sck_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (SCK),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (CS),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // COPI is one stage shorter so its data lines up with the registered
  // SCK edge pulse.
  logic [COPI_STAGES-1:0] copi_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) copi_q <= '0;
    else       copi_q <= {copi_q[COPI_STAGES-2:0], COPI};
  end

  state_t           state_q;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [W-1:0]     tx_sh_q, tx_sh_d;
  logic [W-1:0]     rx_sh_q, rx_sh_d;
  logic [W-1:0]     tx_swap, rx_swap;
  logic             cipo_q;
  logic             hold_q;    // CPHA=0: ignore shift edges until first sample
  logic             done_q;    // word completed on the previous cycle
  logic [W-1:0]     rx_word_q;
  logic             rx_valid_q, tx_load_q, overrun_q, frame_err_q;
  logic             cipo_data;

  assign sample_pulse = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_pulse  = SAMPLE_RISE ? sck_fall : sck_rise;
  assign shift_ok     = shift_pulse && !(!CPHA && hold_q);

  assign bit_cnt_d  = bit_cnt_q + 3'd1;
  assign byte_cnt_d = byte_cnt_q + BCW'(1);
  assign rx_sh_d    = {rx_sh_q[W-2:0], copi_q[COPI_STAGES-1]};
  assign tx_sh_d    = {tx_sh_q[W-2:0], 1'b0};

  // Both shift registers run MSB-first over the whole word with byte 0 at the
  // top, so byte order is swapped on load (tx) and on capture (rx).
  always_comb begin
    tx_swap = '0;
    rx_swap = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      tx_swap[W-8-8*b +: 8] = tx_word[8*b +: 8];
      rx_swap[8*b +: 8]     = rx_sh_q[W-8-8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      cipo_q      <= 1'b0;
      hold_q      <= 1'b0;
      done_q      <= 1'b0;
      rx_word_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      tx_load_q <= 1'b0;
      done_q    <= 1'b0;
      if (rx_ack) rx_valid_q <= 1'b0;
      if (err_clr) begin
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end

      // Later assignments win: a completion overrides rx_ack and error sets
      // override err_clr.
      if (done_q) begin
        rx_word_q  <= rx_swap;
        rx_valid_q <= 1'b1;
        if (rx_valid_q && !rx_ack) overrun_q <= 1'b1;
        tx_sh_q    <= tx_swap;
        tx_load_q  <= 1'b1;
        hold_q     <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            tx_sh_q    <= tx_swap;
            tx_load_q  <= 1'b1;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            hold_q     <= 1'b1;
            cipo_q     <= 1'b0;
            state_q    <= XFER;
          end
        end
        XFER: begin
          if (cs_rise) begin
            if (bit_cnt_q != 3'd0 || byte_cnt_q != '0) frame_err_q <= 1'b1;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            state_q    <= IDLE;
          end else if (sample_pulse) begin
            rx_sh_q   <= rx_sh_d;
            bit_cnt_q <= bit_cnt_d;
            hold_q    <= 1'b0;
            if (bit_cnt_q == 3'd7) begin
              // byte_cnt wraps straight to 0 at word end so a CS release
              // right after a full word never looks like a partial frame.
              if (byte_cnt_q == LAST_BYTE) begin
                byte_cnt_q <= '0;
                done_q     <= 1'b1;
              end else begin
                byte_cnt_q <= byte_cnt_d;
              end
            end
          end else if (shift_ok) begin
            tx_sh_q <= tx_sh_d;
            if (CPHA) cipo_q <= tx_sh_q[W-1];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // CPHA=0 presents the current MSB directly; CPHA=1 updates on shift edges.
  assign cipo_data = CPHA ? cipo_q : tx_sh_q[W-1];

`ifdef SPI_CIPO_TRISTATE_EN
  assign CIPO = (state_q == XFER) ? cipo_data : 1'bz;
`else
  assign CIPO = (state_q == XFER) & cipo_data;
`endif

  assign tx_load   = tx_load_q;
  assign rx_word   = rx_word_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_word_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_word_peripheral
// Purpose  : Self-checking bench. Four instances cover mode 0 (2-byte words)
//            and modes 1..3 (1-byte words); a table of directed vectors plus
//            hand-written sequences for overrun, frame error, ack/completion
//            collision, CS latency and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_word_peripheral;

  localparam int H = 8;  // SCK half period in clk cycles

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sck   [0:3];
  logic        cs    [0:3];
  logic        copi  [0:3];
  wire         cipo  [0:3];
  logic        rx_ack  [0:3];
  logic        err_clr [0:3];
  logic        tl    [0:3];
  logic        rxv   [0:3];
  logic        ovr   [0:3];
  logic        fe    [0:3];
  logic [15:0] tx0;
  logic [15:0] rxw0;
  logic [7:0]  tx8   [1:3];
  logic [7:0]  rx8   [1:3];
  int          tl_cnt [0:3];

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  spi_word_peripheral #(.WORD_BYTES(2), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(3)) dut0 (
    .clk(clk), .reset(reset), .SCK(sck[0]), .CS(cs[0]), .COPI(copi[0]), .CIPO(cipo[0]),
    .tx_word(tx0), .tx_load(tl[0]), .rx_word(rxw0), .rx_valid(rxv[0]), .rx_ack(rx_ack[0]),
    .overrun(ovr[0]), .frame_err(fe[0]), .err_clr(err_clr[0]));

  spi_word_peripheral #(.WORD_BYTES(1), .CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(3)) dut1 (
    .clk(clk), .reset(reset), .SCK(sck[1]), .CS(cs[1]), .COPI(copi[1]), .CIPO(cipo[1]),
    .tx_word(tx8[1]), .tx_load(tl[1]), .rx_word(rx8[1]), .rx_valid(rxv[1]), .rx_ack(rx_ack[1]),
    .overrun(ovr[1]), .frame_err(fe[1]), .err_clr(err_clr[1]));

  spi_word_peripheral #(.WORD_BYTES(1), .CPOL(1'b1), .CPHA(1'b0), .SYNC_STAGES(3)) dut2 (
    .clk(clk), .reset(reset), .SCK(sck[2]), .CS(cs[2]), .COPI(copi[2]), .CIPO(cipo[2]),
    .tx_word(tx8[2]), .tx_load(tl[2]), .rx_word(rx8[2]), .rx_valid(rxv[2]), .rx_ack(rx_ack[2]),
    .overrun(ovr[2]), .frame_err(fe[2]), .err_clr(err_clr[2]));

  spi_word_peripheral #(.WORD_BYTES(1), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(3)) dut3 (
    .clk(clk), .reset(reset), .SCK(sck[3]), .CS(cs[3]), .COPI(copi[3]), .CIPO(cipo[3]),
    .tx_word(tx8[3]), .tx_load(tl[3]), .rx_word(rx8[3]), .rx_valid(rxv[3]), .rx_ack(rx_ack[3]),
    .overrun(ovr[3]), .frame_err(fe[3]), .err_clr(err_clr[3]));

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (tl[i] === 1'b1) tl_cnt[i] = tl_cnt[i] + 1;
  end

  function automatic bit cpol_of(input int idx);
    return (idx >= 2);
  endfunction

  function automatic bit cpha_of(input int idx);
    return (idx == 1 || idx == 3);
  endfunction

  function automatic logic [15:0] rxw(input int idx);
    if (idx == 0) return rxw0;
    return {8'h00, rx8[idx]};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_tx(input int idx, input logic [15:0] w);
    if (idx == 0) tx0 = w;
    else          tx8[idx] = w[7:0];
  endtask

  // Runs right after a sample edge has been driven. Optionally pulses rx_ack
  // in the exact cycle the completed word is being committed.
  task automatic sample_wait(input int idx, input bit ack_now,
                             input logic [15:0] old_w, input logic [15:0] new_w);
    if (ack_now) begin
      wait_clk(4);
      chk("ack_pre_word", rxw(idx), old_w);
      rx_ack[idx] = 1'b1;
      wait_clk(1);
      rx_ack[idx] = 1'b0;
      chk("ack_post_word", rxw(idx), new_w);
      chk("ack_valid", {15'd0, rxv[idx]}, 16'd1);
      chk("ack_overrun", {15'd0, ovr[idx]}, 16'd0);
      wait_clk(H - 5);
    end else begin
      wait_clk(H);
    end
  endtask

  // Controller side: sends mosi[15 -: nbits] MSB first, records CIPO
  // left-aligned into miso.
  task automatic spi_xfer(input int idx, input int nbits, input logic [15:0] mosi,
                          input bit raise_cs, input bit ack_last,
                          input logic [15:0] old_w, input logic [15:0] new_w,
                          output logic [15:0] miso);
    bit cpol = cpol_of(idx);
    bit cpha = cpha_of(idx);
    miso = '0;
    cs[idx] = 1'b0;
    wait_clk(2 * H);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        copi[idx] = mosi[15-i];
        wait_clk(H);
        miso[15-i] = cipo[idx];
        sck[idx] = ~cpol;
        sample_wait(idx, ack_last && (i == nbits - 1), old_w, new_w);
        sck[idx] = cpol;
      end else begin
        sck[idx] = ~cpol;
        copi[idx] = mosi[15-i];
        wait_clk(H);
        miso[15-i] = cipo[idx];
        sck[idx] = cpol;
        sample_wait(idx, ack_last && (i == nbits - 1), old_w, new_w);
      end
    end
    wait_clk(H);
    if (raise_cs) begin
      cs[idx] = 1'b1;
      copi[idx] = 1'b0;
      wait_clk(2 * H);
    end
  endtask

  task automatic ack(input int idx);
    rx_ack[idx] = 1'b1;
    wait_clk(1);
    rx_ack[idx] = 1'b0;
    wait_clk(1);
  endtask

  task automatic eclr(input int idx);
    err_clr[idx] = 1'b1;
    wait_clk(1);
    err_clr[idx] = 1'b0;
    wait_clk(1);
  endtask

  typedef struct {
    int          idx;
    int          nbits;
    logic [15:0] mosi;
    logic [15:0] tx;
    logic [15:0] exp_rx;
    logic [15:0] exp_miso;
  } vec_t;

  vec_t vecs [0:5];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] miso;
    int base;

    for (int i = 0; i < 4; i++) begin
      sck[i] = cpol_of(i);
      cs[i] = 1'b1;
      copi[i] = 1'b0;
      rx_ack[i] = 1'b0;
      err_clr[i] = 1'b0;
      tl_cnt[i] = 0;
    end
    tx0 = '0;
    for (int i = 1; i < 4; i++) tx8[i] = '0;

    vecs[0] = '{0, 16, 16'h3412, 16'hA55A, 16'h1234, 16'h5AA5};
    vecs[1] = '{0, 16, 16'hBEEF, 16'h0F81, 16'hEFBE, 16'h810F};
    vecs[2] = '{1,  8, 16'hC300, 16'h003C, 16'h00C3, 16'h3C00};
    vecs[3] = '{2,  8, 16'hC300, 16'h003C, 16'h00C3, 16'h3C00};
    vecs[4] = '{3,  8, 16'hC300, 16'h003C, 16'h00C3, 16'h3C00};
    vecs[5] = '{3,  8, 16'h5A00, 16'h00A7, 16'h005A, 16'hA700};

    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);

    // Reset state
    for (int i = 0; i < 4; i++) begin
      chk("rst_rx_word", rxw(i), 16'h0000);
      chk("rst_flags", {12'd0, rxv[i], ovr[i], fe[i], tl[i]}, 16'h0000);
      chk("rst_cipo", {15'd0, cipo[i]}, 16'h0000);
    end

    // Directed vectors
    for (int v = 0; v < 6; v++) begin
      set_tx(vecs[v].idx, vecs[v].tx);
      base = tl_cnt[vecs[v].idx];
      spi_xfer(vecs[v].idx, vecs[v].nbits, vecs[v].mosi, 1'b1, 1'b0, '0, '0, miso);
      chk("vec_rx_word", rxw(vecs[v].idx), vecs[v].exp_rx);
      chk("vec_rx_valid", {15'd0, rxv[vecs[v].idx]}, 16'd1);
      chk("vec_cipo", miso, vecs[v].exp_miso);
      chk("vec_tx_load_cnt", 16'(tl_cnt[vecs[v].idx] - base), 16'd2);
      chk("vec_errs", {14'd0, ovr[vecs[v].idx], fe[vecs[v].idx]}, 16'd0);
      ack(vecs[v].idx);
      chk("vec_ack_clears", {15'd0, rxv[vecs[v].idx]}, 16'd0);
    end

    // CS pin to tx_load latency (SYNC_STAGES+1 = 4 clocks), empty frame
    cs[1] = 1'b0;
    wait_clk(3);
    chk("cs_lat_early", {15'd0, tl[1]}, 16'd0);
    wait_clk(1);
    chk("cs_lat_pulse", {15'd0, tl[1]}, 16'd1);
    wait_clk(1);
    chk("cs_lat_single", {15'd0, tl[1]}, 16'd0);
    cs[1] = 1'b1;
    wait_clk(2 * H);
    chk("empty_frame_no_err", {15'd0, fe[1]}, 16'd0);

    // Overrun: two words without ack, then err_clr
    tx8[1] = 8'h00;
    spi_xfer(1, 8, 16'h1100, 1'b1, 1'b0, '0, '0, miso);
    chk("ovr_first_none", {15'd0, ovr[1]}, 16'd0);
    spi_xfer(1, 8, 16'h2200, 1'b1, 1'b0, '0, '0, miso);
    chk("ovr_set", {15'd0, ovr[1]}, 16'd1);
    chk("ovr_rx_word", rxw(1), 16'h0022);
    eclr(1);
    chk("ovr_cleared", {15'd0, ovr[1]}, 16'd0);
    chk("ovr_valid_kept", {15'd0, rxv[1]}, 16'd1);
    ack(1);

    // Frame error: 13 bits then CS release, then a good word
    tx0 = 16'hA55A;
    spi_xfer(0, 13, 16'hFFF8, 1'b1, 1'b0, '0, '0, miso);
    chk("fe_set", {15'd0, fe[0]}, 16'd1);
    chk("fe_no_valid", {15'd0, rxv[0]}, 16'd0);
    eclr(0);
    chk("fe_cleared", {15'd0, fe[0]}, 16'd0);
    spi_xfer(0, 16, 16'h7856, 1'b1, 1'b0, '0, '0, miso);
    chk("fe_next_word", rxw(0), 16'h5678);
    chk("fe_next_cipo", miso, 16'h5AA5);
    chk("fe_next_no_err", {15'd0, fe[0]}, 16'd0);
    ack(0);

    // rx_ack coincident with completion: completion wins, no overrun
    tx8[2] = 8'h00;
    spi_xfer(2, 8, 16'h9600, 1'b1, 1'b0, '0, '0, miso);
    spi_xfer(2, 8, 16'h6900, 1'b1, 1'b1, 16'h0096, 16'h0069, miso);
    chk("coinc_valid_after", {15'd0, rxv[2]}, 16'd1);
    chk("coinc_no_overrun", {15'd0, ovr[2]}, 16'd0);
    ack(2);

    // Asynchronous reset mid-byte
    tx0 = 16'hA55A;
    spi_xfer(0, 16, 16'h3412, 1'b1, 1'b0, '0, '0, miso);
    chk("prerst_valid", {15'd0, rxv[0]}, 16'd1);
    spi_xfer(0, 5, 16'hF800, 1'b0, 1'b0, '0, '0, miso);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rx_word", rxw(0), 16'h0000);
    chk("arst_flags", {12'd0, rxv[0], ovr[0], fe[0], tl[0]}, 16'h0000);
    cs[0] = 1'b1;
    sck[0] = 1'b0;
    copi[0] = 1'b0;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(4);
    chk("arst_no_frame_err", {15'd0, fe[0]}, 16'd0);
    spi_xfer(0, 16, 16'h3412, 1'b1, 1'b0, '0, '0, miso);
    chk("arst_next_word", rxw(0), 16'h1234);
    chk("arst_next_cipo", miso, 16'h5AA5);
    ack(0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
